// File: rtl/ibex_alu_iter_if.sv
// Request/response bundle for the iterative ALU: operands and op in,
// registered result and flags out, each direction with its own valid/ready.
interface ibex_alu_iter_if #(
    parameter int WIDTH = 32
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] operand_a_i;
    logic [WIDTH-1:0] operand_b_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             cmp_result_o;
    logic             is_equal_o;
    logic             busy_o;

    modport slave (
        input  req_valid_i, op_i, operand_a_i, operand_b_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o, carry_o, cmp_result_o,
               is_equal_o, busy_o
    );

    modport master (
        output req_valid_i, op_i, operand_a_i, operand_b_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o, carry_o, cmp_result_o,
               is_equal_o, busy_o
    );
endinterface

// File: rtl/ibex_alu_iter.sv
// Handshaked ALU: single-cycle ADD/SUB/logic/SLTU plus an iterative
// carry-less multiply retiring BITS_PER_CYCLE multiplier bits per cycle.
module ibex_alu_iter #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ibex_alu_iter_if.slave bus
);
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_hi;
    logic [WIDTH-1:0]     r_a, r_b;
    logic [1:0][WIDTH-1:0] r_imd;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic                 r_carry, r_cmp, r_eq;

    logic                 w_accept, w_is_clmul, w_last;
    logic [WIDTH:0]       w_sum, w_diff;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_carry;
    logic [2*WIDTH-1:0]   w_a_ext, w_acc;
    logic [IDX_W-1:0]     w_idx;

    assign w_is_clmul = (bus.op_i[2:1] == 2'b11);
    assign w_last     = (r_cnt == CNT_W'(STEPS - 1));

    // Subtraction as A + ~B + 1 so bit WIDTH is the not-borrow flag.
    assign w_sum  = {1'b0, bus.operand_a_i} + {1'b0, bus.operand_b_i};
    assign w_diff = {1'b0, bus.operand_a_i} + {1'b0, ~bus.operand_b_i}
                  + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (bus.op_i)
            3'd0: begin w_alu_res = w_sum[WIDTH-1:0];  w_alu_carry = w_sum[WIDTH];  end
            3'd1: begin w_alu_res = w_diff[WIDTH-1:0]; w_alu_carry = w_diff[WIDTH]; end
            3'd2: w_alu_res = bus.operand_a_i & bus.operand_b_i;
            3'd3: w_alu_res = bus.operand_a_i | bus.operand_b_i;
            3'd4: w_alu_res = bus.operand_a_i ^ bus.operand_b_i;
            3'd5: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.operand_a_i < bus.operand_b_i)};
            default: ;
        endcase
    end

    // One CALC step: fold the next BITS_PER_CYCLE partial products into imd.
    assign w_a_ext = {{WIDTH{1'b0}}, r_a};
    always_comb begin
        w_acc = r_imd;
        w_idx = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_idx = IDX_W'(int'(r_cnt) * BITS_PER_CYCLE + k);
            if (r_b[w_idx])
                w_acc = w_acc ^ (w_a_ext << w_idx);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.req_valid_i;
                if (bus.req_valid_i)
                    w_state_nxt = w_is_clmul ? S_CALC : S_RESP;
            end
            S_CALC: if (w_last) w_state_nxt = S_RESP;
            S_RESP: if (bus.resp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        bus.req_ready_o  = (r_state == S_IDLE);
        bus.resp_valid_o = (r_state == S_RESP);
        bus.busy_o       = (r_state != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_hi     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_imd    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_cmp    <= 1'b0;
            r_eq     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_hi  <= bus.op_i[0];
                    r_a   <= bus.operand_a_i;
                    r_b   <= bus.operand_b_i;
                    r_cmp <= (bus.operand_a_i < bus.operand_b_i);
                    r_eq  <= (bus.operand_a_i == bus.operand_b_i);
                    if (w_is_clmul) begin
                        r_imd   <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                    end else begin
                        r_result <= w_alu_res;
                        r_carry  <= w_alu_carry;
                    end
                end
                S_CALC: begin
                    r_imd <= w_acc;
                    if (w_last)
                        r_result <= r_hi ? w_acc[2*WIDTH-1:WIDTH] : w_acc[WIDTH-1:0];
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.result_o     = r_result;
    assign bus.carry_o      = r_carry;
    assign bus.cmp_result_o = r_cmp;
    assign bus.is_equal_o   = r_eq;
endmodule

// File: tb/tb_ibex_alu_iter.sv
// Directed bench: two instances (1 and 4 bits per cycle) share one stimulus
// stream; expected results and latencies are hand-computed constants.
module tb_ibex_alu_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, resp_ready;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ibex_alu_iter_if #(.WIDTH(32)) b1 ();
    ibex_alu_iter_if #(.WIDTH(32)) b4 ();

    assign b1.req_valid_i  = req_valid;
    assign b1.op_i         = op;
    assign b1.operand_a_i  = a;
    assign b1.operand_b_i  = b;
    assign b1.resp_ready_i = resp_ready;
    assign b4.req_valid_i  = req_valid;
    assign b4.op_i         = op;
    assign b4.operand_a_i  = a;
    assign b4.operand_b_i  = b;
    assign b4.resp_ready_i = resp_ready;

    ibex_alu_iter #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    ibex_alu_iter #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (.clk_i(clk), .rst_i(rst), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "/vld1"}, 32'(b1.resp_valid_o), 0);
        chk({tag, "/vld4"}, 32'(b4.resp_valid_o), 0);
        chk({tag, "/bsy1"}, 32'(b1.busy_o), 0);
        chk({tag, "/bsy4"}, 32'(b4.busy_o), 0);
        chk({tag, "/rdy1"}, 32'(b1.req_ready_o), 1);
        chk({tag, "/rdy4"}, 32'(b4.req_ready_o), 1);
    endtask

    task automatic run_op(input string name, input logic [2:0] op_, input logic [31:0] a_,
                          input logic [31:0] b_, input logic [31:0] res, input logic c,
                          input logic lt, input logic eq, input int lat1, input int lat4);
        int l1, l4;
        @(negedge clk);
        op = op_; a = a_; b = b_; req_valid = 1'b1; resp_ready = 1'b0;
        chk({name, "/rdy1"}, 32'(b1.req_ready_o), 1);
        @(posedge clk); #1;
        // scramble inputs after accept: the captured operands must be used
        req_valid = 1'b0; op = 3'd2; a = ~a_; b = ~b_;
        l1 = 0; l4 = 0;
        for (int cyc = 1; cyc <= 100 && (l1 == 0 || l4 == 0); cyc++) begin
            if (l1 == 0 && b1.resp_valid_o) l1 = cyc;
            if (l4 == 0 && b4.resp_valid_o) l4 = cyc;
            if (l1 == 0 || l4 == 0) begin @(posedge clk); #1; end
        end
        chk({name, "/lat1"}, 32'(l1), 32'(lat1));
        chk({name, "/lat4"}, 32'(l4), 32'(lat4));
        chk({name, "/res1"}, b1.result_o, res);
        chk({name, "/res4"}, b4.result_o, res);
        chk({name, "/cy1"},  32'(b1.carry_o), 32'(c));
        chk({name, "/cmp1"}, 32'(b1.cmp_result_o), 32'(lt));
        chk({name, "/eq1"},  32'(b1.is_equal_o), 32'(eq));
        chk({name, "/eq4"},  32'(b4.is_equal_o), 32'(eq));
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        idle_chk({name, "/done"});
        resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ea, eb;
        int seen;
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_chk("reset");
        chk("reset/res1", b1.result_o, 0);
        chk("reset/cy1", 32'(b1.carry_o), 0);

        run_op("and",    3'd2, 32'hFFFFFF00, 32'h00FFFFFF, 32'h00FFFF00, 0, 0, 0, 1, 1);
        run_op("add",    3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0, 1, 1);
        run_op("sub",    3'd1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 1, 0, 1, 1);
        run_op("subeq",  3'd1, 32'h00000007, 32'h00000007, 32'h00000000, 1, 0, 1, 1, 1);
        run_op("or",     3'd3, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 0, 0, 0, 1, 1);
        run_op("xor",    3'd4, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0, 1, 0, 1, 1);
        run_op("sltu1",  3'd5, 32'h00000003, 32'h00000008, 32'h00000001, 0, 1, 0, 1, 1);
        run_op("sltu0",  3'd5, 32'h00000008, 32'h00000003, 32'h00000000, 0, 0, 0, 1, 1);
        run_op("clmul",  3'd6, 32'h00000003, 32'h00000003, 32'h00000005, 0, 0, 1, 33, 9);
        run_op("clmulh", 3'd7, 32'h80000000, 32'h00000002, 32'h00000001, 0, 0, 0, 33, 9);
        run_op("clmulb0",3'd6, 32'h12345678, 32'h00000000, 32'h00000000, 0, 0, 0, 33, 9);
        run_op("clmulff",3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 0, 0, 1, 33, 9);
        run_op("clmulhf",3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 0, 0, 1, 33, 9);

        // backpressure with a competing request held high during RESP
        @(negedge clk);
        op = 3'd0; a = 32'h10; b = 32'h20; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        op = 3'd4; a = 32'hFFFF_FFFF; b = 32'h1;
        for (int i = 0; i < 5; i++) begin
            chk("bp/vld",  32'(b1.resp_valid_o), 1);
            chk("bp/rdy",  32'(b1.req_ready_o), 0);
            chk("bp/res",  b1.result_o, 32'h30);
            chk("bp/cmp",  32'(b1.cmp_result_o), 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        idle_chk("bp/rel");
        seen = 0;
        repeat (3) begin @(posedge clk); #1; if (b1.resp_valid_o || b4.resp_valid_o) seen++; end
        chk("bp/noaccept", 32'(seen), 0);
        chk("bp/res_kept", b1.result_o, 32'h30);

        // streaming XORs with resp_ready tied high: one accept per two cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ea = 32'h01010101 * (i + 1) + 32'h5A;
            eb = 32'hF00F0000 >> i;
            op = 3'd4; a = ea; b = eb; req_valid = 1'b1;
            chk("b2b/rdy", 32'(b1.req_ready_o), 1);
            @(negedge clk);
            chk("b2b/vld", 32'(b1.resp_valid_o), 1);
            chk("b2b/res1", b1.result_o, ea ^ eb);
            chk("b2b/res4", b4.result_o, ea ^ eb);
            chk("b2b/busy", 32'(b1.req_ready_o), 0);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // reset in the middle of a CLMUL aborts it without a response
        @(negedge clk);
        op = 3'd6; a = 32'h0000FFFF; b = 32'h0000FFFF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        chk("rst/calc_busy", 32'(b1.busy_o), 1);
        @(negedge clk);
        rst = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_chk("rst");
        chk("rst/res1", b1.result_o, 0);
        chk("rst/res4", b4.result_o, 0);
        chk("rst/eq1", 32'(b1.is_equal_o), 0);
        chk("rst/cmp4", 32'(b4.cmp_result_o), 0);
        seen = 0;
        repeat (50) begin @(posedge clk); #1; if (b1.resp_valid_o || b4.resp_valid_o) seen++; end
        chk("rst/noresp", 32'(seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
